// File: rtl/temp_pkg.sv
// Shared types and defaults for the temperature sensor sampler and its downstream buffer.
package temp_pkg;

  typedef logic [7:0] temp_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } sampler_state_t;

  localparam int FRAME_BITS_DEF = 16;
  localparam int TEMP_LSB_DEF   = 7;

  // Negative readings clamp to zero; the buffer stores unsigned temperatures only.
  function automatic temp_t clamp_temp(input logic sign, input temp_t raw);
    return sign ? temp_t'(0) : raw;
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Sensor bus plus sample output bundle between the sampler, the sensor pins and the buffer.
interface temp_sampler_if;
  import temp_pkg::*;

  logic  enable;
  logic  miso;
  logic  cs_n;
  logic  sclk;
  temp_t sample;
  logic  sample_valid;
  logic  busy;

  modport master (
    input  enable,
    input  miso,
    output cs_n,
    output sclk,
    output sample,
    output sample_valid,
    output busy
  );

  modport slave (
    output enable,
    output miso,
    input  cs_n,
    input  sclk,
    input  sample,
    input  sample_valid,
    input  busy
  );

endinterface

// File: rtl/sample_timer.sv
// Free-running period counter; emits a one-cycle trigger on each wrap while enabled.
module sample_timer #(
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_trigger
);

  localparam int            CW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap    = i_enable && (r_count == LAST);
  assign o_trigger = w_wrap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!i_enable || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// Periodic read-only serial sensor reader: frames chip select and sclk, shifts the reading in, emits one sample per period.
module temp_sampler
  import temp_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SCLK_DIV      = 4,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int TEMP_LSB      = TEMP_LSB_DEF
) (
  input  logic           clk,
  input  logic           reset,
  temp_sampler_if.master bus
);

  localparam int            DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int            BW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  sampler_state_t        r_state;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic                  r_high;
  logic [FRAME_BITS-1:0] r_shift;
  logic [1:0]            r_miso_sync;
  temp_t                 r_sample;
  logic                  r_valid;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic                  r_busy;

  sampler_state_t        w_state_nxt;
  logic [DW-1:0]         w_div_nxt;
  logic [BW-1:0]         w_bit_nxt;
  logic                  w_high_nxt;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  temp_t                 w_sample_nxt;
  logic                  w_valid_nxt;
  logic                  w_cs_n_nxt;
  logic                  w_sclk_nxt;
  logic                  w_trigger;
  logic                  w_miso;
  temp_t                 w_temp;

  sample_timer #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (bus.enable),
    .o_trigger (w_trigger)
  );

  assign w_miso = r_miso_sync[1];
  assign w_temp = clamp_temp(r_shift[FRAME_BITS-1], r_shift[TEMP_LSB +: 8]);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;
    w_high_nxt   = r_high;
    w_shift_nxt  = r_shift;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_cs_n_nxt   = 1'b1;
    w_sclk_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nxt = SETUP;
          w_div_nxt   = '0;
          w_cs_n_nxt  = 1'b0;
        end
      end

      SETUP: begin
        w_cs_n_nxt = 1'b0;
        if (r_div == DIV_LAST) begin
          w_state_nxt = SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_high_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end

      SHIFT: begin
        w_cs_n_nxt = 1'b0;
        w_sclk_nxt = r_high;
        if (r_div != DIV_LAST) begin
          w_div_nxt = r_div + DW'(1);
        end else if (!r_high) begin
          // Capture coincides with the rising sclk edge we are about to drive.
          w_div_nxt   = '0;
          w_high_nxt  = 1'b1;
          w_sclk_nxt  = 1'b1;
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_miso};
        end else if (r_bit == BIT_LAST) begin
          w_state_nxt  = DONE;
          w_cs_n_nxt   = 1'b1;
          w_sclk_nxt   = 1'b0;
          w_valid_nxt  = 1'b1;
          w_sample_nxt = w_temp;
        end else begin
          w_div_nxt  = '0;
          w_bit_nxt  = r_bit + BW'(1);
          w_high_nxt = 1'b0;
          w_sclk_nxt = 1'b0;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_high      <= 1'b0;
      r_shift     <= '0;
      r_miso_sync <= '0;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_bit       <= w_bit_nxt;
      r_high      <= w_high_nxt;
      r_shift     <= w_shift_nxt;
      r_miso_sync <= {r_miso_sync[0], bus.miso};
      r_sample    <= w_sample_nxt;
      r_valid     <= w_valid_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_sclk      <= w_sclk_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign bus.cs_n         = r_cs_n;
  assign bus.sclk         = r_sclk;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.busy         = r_busy;

  // A trigger outside IDLE is silently dropped; it can only happen with a too-short period.
  a_trigger_only_when_idle: assert property (
    @(posedge clk) disable iff (reset) w_trigger |-> (r_state == IDLE)
  );

endmodule

// File: tb/tb_temp_sampler.sv
// Directed bench for temp_sampler: behavioural sensor, frame table, and enable/reset corner sequences.
module tb_temp_sampler;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_sample;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  temp_sampler_if bus ();

  temp_sampler #(
    .SAMPLE_PERIOD (100),
    .SCLK_DIV      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt       = 0;
  int check_cnt      = 0;
  int cyc            = 0;
  int sclk_rises     = 0;
  int last_valid_cyc = 0;
  int last_rises     = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge bus.sclk) sclk_rises++;

  // Sensor: loads its frame when selected, presents the next bit after each rising sclk.
  logic [15:0] sensor_frame = 16'h0000;
  logic [15:0] sens_sr      = 16'h0000;
  assign bus.miso = sens_sr[15];
  always @(negedge bus.cs_n or posedge bus.sclk) begin
    if (bus.sclk) sens_sr = {sens_sr[14:0], 1'b0};
    else          sens_sr = sensor_frame;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.sample_valid === 1'b1) seen = 1'b1;
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_cs_low(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.cs_n === 1'b0) seen = 1'b1;
    end
    check({name, "_cs_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_rises(input string name, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sclk_rises - last_rises >= n) seen = 1'b1;
    end
    check({name, "_rises_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp, input bit chk_period);
    wait_valid(name, 250);
    check({name, "_sample"}, 32'(bus.sample), 32'(exp));
    if (chk_period) check({name, "_period"}, cyc - last_valid_cyc, 100);
    check({name, "_sclk_pulses"}, sclk_rises - last_rises, 16);
    last_valid_cyc = cyc;
    last_rises     = sclk_rises;
    @(negedge clk);
    check({name, "_pulse_width"}, 32'(bus.sample_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    int   t0;
    int   bad;

    vecs[0] = '{16'h1900, 8'h32};
    vecs[1] = '{16'h1980, 8'h33};
    vecs[2] = '{16'h1A00, 8'h34};
    vecs[3] = '{16'h7F80, 8'hFF};
    vecs[4] = '{16'h0080, 8'h01};
    vecs[5] = '{16'h007F, 8'h00};
    vecs[6] = '{16'h8000, 8'h00};
    vecs[7] = '{16'h1900, 8'h32};

    reset      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",   32'(bus.cs_n),         32'd1);
    check("rst_sclk",   32'(bus.sclk),         32'd0);
    check("rst_sample", 32'(bus.sample),       32'd0);
    check("rst_valid",  32'(bus.sample_valid), 32'd0);
    check("rst_busy",   32'(bus.busy),         32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.cs_n !== 1'b1 || bus.sclk !== 1'b0 || bus.sample !== 8'h00 ||
          bus.sample_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("disabled_idle_500", bad, 0);

    // First frame: cs_n after exactly one period, valid 67 cycles after the trigger cycle.
    sensor_frame = 16'h1900;
    @(posedge clk);
    #1 bus.enable = 1'b1;
    t0 = cyc;
    wait_cs_low("first", 200);
    check("first_cs_latency", cyc - t0, 100);
    check("first_busy", 32'(bus.busy), 32'd1);
    check_frame("first", 8'h32, 1'b0);
    check("first_valid_latency", last_valid_cyc - t0, 166);

    sensor_frame = 16'hF000;
    check_frame("negative", 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) begin
      sensor_frame = vecs[i].frame;
      check_frame($sformatf("vec%0d", i), vecs[i].exp_sample, 1'b1);
    end

    // enable falls during bit 5: frame finishes, then the sensor bus stays quiet.
    sensor_frame = 16'h1A00;
    wait_cs_low("drop", 150);
    wait_rises("drop", 5);
    @(posedge clk);
    #1 bus.enable = 1'b0;
    check_frame("drop", 8'h34, 1'b1);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.cs_n !== 1'b1 || bus.sclk !== 1'b0 || bus.sample_valid !== 1'b0 ||
          bus.busy !== 1'b0) bad++;
    end
    check("drop_quiet_300", bad, 0);
    check("drop_sclk_quiet", sclk_rises - last_rises, 0);

    // Short enable glitch restarts the period count.
    sensor_frame = 16'h1900;
    @(posedge clk);
    #1 bus.enable = 1'b1;
    repeat (50) @(posedge clk);
    #1 bus.enable = 1'b0;
    @(posedge clk);
    #1 bus.enable = 1'b1;
    t0 = cyc;
    wait_cs_low("restart", 200);
    check("restart_cs_latency", cyc - t0, 100);

    // Asynchronous reset between edges in the middle of SHIFT.
    wait_rises("midreset", 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_cs_n",   32'(bus.cs_n),         32'd1);
    check("midreset_sclk",   32'(bus.sclk),         32'd0);
    check("midreset_busy",   32'(bus.busy),         32'd0);
    check("midreset_valid",  32'(bus.sample_valid), 32'd0);
    check("midreset_sample", 32'(bus.sample),       32'd0);
    bus.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.sample_valid !== 1'b0 || bus.cs_n !== 1'b1) bad++;
    end
    check("midreset_no_valid", bad, 0);
    check("midreset_sample_held", 32'(bus.sample), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
